// File: rtl/cpu_pkg.sv
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared types for the 5-stage CPU hazard/forwarding logic.
//            - forwarding-select and hazard-FSM state encodings
//            - the shadow-stage record tracked for each in-flight instruction
//            - a helper that decides whether a shadow stage is a real producer
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

   localparam int CPU_REG_W = 4;

   typedef enum logic [1:0] {
      FWD_RF    = 2'b00,
      FWD_EXMEM = 2'b01,
      FWD_MEMWB = 2'b10
   } fwd_sel_t;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } hz_state_t;

   typedef struct packed {
      logic                 valid;
      logic [CPU_REG_W-1:0] wreg;
      logic                 memrd;
      logic                 regwrite;
   } shadow_t;

   // R0 is hard-wired to zero, so a write to it never produces a value
   // anybody could forward.
   function automatic logic is_writer(input shadow_t s);
      return s.valid && s.regwrite && (s.wreg != '0);
   endfunction

endpackage

`default_nettype wire

// File: rtl/fwd_match.sv
// ============================================================================
// Module   : fwd_match
// Purpose  : Compares one ID-stage source register against the producers
//            currently in the EX and MEM shadow stages and returns the
//            forwarding select the operand will need once it reaches EX.
// Ports    : used     - source is actually read
//            src      - source register address
//            ex_wr    - EX shadow stage is a real producer
//            ex_wreg  - EX shadow destination
//            mem_wr   - MEM shadow stage is a real producer
//            mem_wreg - MEM shadow destination
//            sel      - resulting forwarding select
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_match
   import cpu_pkg::*;
#(
   parameter int REG_W = CPU_REG_W
)(
   input  logic             used,
   input  logic [REG_W-1:0] src,
   input  logic             ex_wr,
   input  logic [REG_W-1:0] ex_wreg,
   input  logic             mem_wr,
   input  logic [REG_W-1:0] mem_wreg,
   output fwd_sel_t         sel
);

   // The EX producer will sit in EX/MEM when this instruction reaches EX,
   // and the MEM producer in MEM/WB; the younger (EX) producer wins.
   always_comb begin
      sel = FWD_RF;
      if (used) begin
         if (ex_wr && (ex_wreg == src)) begin
            sel = FWD_EXMEM;
         end else if (mem_wr && (mem_wreg == src)) begin
            sel = FWD_MEMWB;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Hazard and forwarding controller at the ID/EX boundary. Tracks
//            in-flight destinations in a shadow pipeline and generates
//            registered forwarding selects, load-use stalls, branch flushes
//            and HLT drain sequencing.
// Ports    : clk, rst (async, active-low)
//            id_*            - decoded ID-stage instruction
//            ex_branch_taken - EX resolved a taken control transfer
//            fwd_a, fwd_b    - registered EX operand selects
//            stall_pc, stall_ifid, bubble_idex, flush_ifid - pipeline ctrl
//            halted          - pipeline has drained after HLT
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl
   import cpu_pkg::*;
#(
   parameter int REG_W        = CPU_REG_W,   // must equal CPU_REG_W
   parameter int DRAIN_CYCLES = 3
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_rs_used,
   input  logic             id_rt_used,
   input  logic [REG_W-1:0] id_wreg,
   input  logic             id_regwrite,
   input  logic             id_memread,
   input  logic             id_halt,
   input  logic             ex_branch_taken,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             stall_pc,
   output logic             stall_ifid,
   output logic             bubble_idex,
   output logic             flush_ifid,
   output logic             halted
);

   localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

   // EX keeps the full record (load-use needs memrd); MEM only needs its
   // producer identity. WB is never forwarded from - the register file
   // resolves write-before-read itself - so it is not tracked.
   shadow_t          ex_s;
   logic             mem_wr;
   logic [REG_W-1:0] mem_wreg;

   hz_state_t        state;
   logic [CNT_W-1:0] drain_cnt;

   logic             ex_wr;
   logic             load_use;
   logic             halt_req;
   logic             id_advance;
   fwd_sel_t         sel_a;
   fwd_sel_t         sel_b;
   fwd_sel_t         fwd_a_r;
   fwd_sel_t         fwd_b_r;

   assign ex_wr    = is_writer(ex_s);
   assign halt_req = id_valid && id_halt;
   assign load_use = id_valid && ex_s.memrd && ex_wr &&
                     ((id_rs_used && (id_rs == ex_s.wreg)) ||
                      (id_rt_used && (id_rt == ex_s.wreg)));

   fwd_match #(.REG_W(REG_W)) u_fwd_a (
      .used     (id_rs_used),
      .src      (id_rs),
      .ex_wr    (ex_wr),
      .ex_wreg  (ex_s.wreg),
      .mem_wr   (mem_wr),
      .mem_wreg (mem_wreg),
      .sel      (sel_a)
   );

   fwd_match #(.REG_W(REG_W)) u_fwd_b (
      .used     (id_rt_used),
      .src      (id_rt),
      .ex_wr    (ex_wr),
      .ex_wreg  (ex_s.wreg),
      .mem_wr   (mem_wr),
      .mem_wreg (mem_wreg),
      .sel      (sel_b)
   );

   // Priority: branch flush > load-use stall > halt. A flush never stalls
   // the PC so the branch target is fetched. Everything is forced low while
   // reset is asserted.
   always_comb begin
      stall_pc    = 1'b0;
      stall_ifid  = 1'b0;
      bubble_idex = 1'b0;
      flush_ifid  = 1'b0;
      if (rst) begin
         case (state)
            RUN: begin
               if (ex_branch_taken) begin
                  flush_ifid  = 1'b1;
                  bubble_idex = 1'b1;
               end else if (load_use || halt_req) begin
                  // HLT is held in IF/ID and enters EX as a bubble
                  stall_pc    = 1'b1;
                  stall_ifid  = 1'b1;
                  bubble_idex = 1'b1;
               end
            end
            DRAIN: begin
               if (ex_branch_taken) begin
                  flush_ifid  = 1'b1;
                  bubble_idex = 1'b1;
               end else begin
                  stall_pc    = 1'b1;
                  stall_ifid  = 1'b1;
                  bubble_idex = 1'b1;
               end
            end
            HALTED: begin
               stall_pc    = 1'b1;
               stall_ifid  = 1'b1;
               bubble_idex = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign id_advance = id_valid && !bubble_idex;

   // Shadow pipeline and forwarding selects move together: the selects are
   // computed while the instruction is in ID and captured as it enters EX.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ex_s     <= '0;
         mem_wr   <= 1'b0;
         mem_wreg <= '0;
         fwd_a_r  <= FWD_RF;
         fwd_b_r  <= FWD_RF;
      end else begin
         mem_wr   <= ex_wr;
         mem_wreg <= ex_s.wreg;
         if (id_advance) begin
            ex_s    <= '{valid: 1'b1, wreg: id_wreg, memrd: id_memread,
                         regwrite: id_regwrite};
            fwd_a_r <= sel_a;
            fwd_b_r <= sel_b;
         end else begin
            ex_s    <= '0;
            fwd_a_r <= FWD_RF;
            fwd_b_r <= FWD_RF;
         end
      end
   end

   assign fwd_a = fwd_a_r;
   assign fwd_b = fwd_b_r;

   // Drain counter loads DRAIN_CYCLES on acceptance and counts down; the
   // move to HALTED happens on the edge where the count reaches 1, so
   // halted rises DRAIN_CYCLES edges after the cycle HLT sat in ID.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= RUN;
         drain_cnt <= '0;
         halted    <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (halt_req && !ex_branch_taken && !load_use) begin
                  state     <= DRAIN;
                  drain_cnt <= CNT_W'(DRAIN_CYCLES);
               end
            end
            DRAIN: begin
               if (ex_branch_taken) begin
                  // branch older than HLT: HLT is squashed, resume fetch
                  state <= RUN;
               end else if (drain_cnt <= CNT_W'(2)) begin
                  state  <= HALTED;
                  halted <= 1'b1;
               end else begin
                  drain_cnt <= drain_cnt - CNT_W'(1);
               end
            end
            HALTED: ;
            default: state <= RUN;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none

module tb_hazard_ctrl;

   localparam int DRAIN = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       id_valid, id_rs_used, id_rt_used, id_regwrite, id_memread;
   logic       id_halt, ex_branch_taken;
   logic [3:0] id_rs, id_rt, id_wreg;
   logic [1:0] fwd_a, fwd_b;
   logic       stall_pc, stall_ifid, bubble_idex, flush_ifid, halted;

   always #5 clk = ~clk;

   hazard_ctrl #(.REG_W(4), .DRAIN_CYCLES(DRAIN)) dut (
      .clk             (clk),
      .rst             (rst),
      .id_valid        (id_valid),
      .id_rs           (id_rs),
      .id_rt           (id_rt),
      .id_rs_used      (id_rs_used),
      .id_rt_used      (id_rt_used),
      .id_wreg         (id_wreg),
      .id_regwrite     (id_regwrite),
      .id_memread      (id_memread),
      .id_halt         (id_halt),
      .ex_branch_taken (ex_branch_taken),
      .fwd_a           (fwd_a),
      .fwd_b           (fwd_b),
      .stall_pc        (stall_pc),
      .stall_ifid      (stall_ifid),
      .bubble_idex     (bubble_idex),
      .flush_ifid      (flush_ifid),
      .halted          (halted)
   );

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      logic       v;
      logic [3:0] rs;
      logic [3:0] rt;
      logic       rsu;
      logic       rtu;
      logic [3:0] wr;
      logic       rw;
      logic       mr;
      logic       hl;
      logic       br;
      logic [1:0] fa;
      logic [1:0] fb;
      logic       spc;
      logic       sif;
      logic       bub;
      logic       fl;
      logic       ho;
   } vec_t;

   vec_t tbl [27];

   function automatic vec_t mk(
      input logic v, input logic [3:0] rs, input logic [3:0] rt,
      input logic rsu, input logic rtu, input logic [3:0] wr,
      input logic rw, input logic mr, input logic hl, input logic br,
      input logic [1:0] fa, input logic [1:0] fb, input logic spc,
      input logic sif, input logic bub, input logic fl, input logic ho);
      vec_t t;
      t.v = v; t.rs = rs; t.rt = rt; t.rsu = rsu; t.rtu = rtu; t.wr = wr;
      t.rw = rw; t.mr = mr; t.hl = hl; t.br = br; t.fa = fa; t.fb = fb;
      t.spc = spc; t.sif = sif; t.bub = bub; t.fl = fl; t.ho = ho;
      return t;
   endfunction

   task automatic drive(
      input logic v, input logic [3:0] rs, input logic [3:0] rt,
      input logic rsu, input logic rtu, input logic [3:0] wr,
      input logic rw, input logic mr, input logic hl, input logic br);
      id_valid = v; id_rs = rs; id_rt = rt; id_rs_used = rsu;
      id_rt_used = rtu; id_wreg = wr; id_regwrite = rw; id_memread = mr;
      id_halt = hl; ex_branch_taken = br;
   endtask

   task automatic check(
      input string name, input logic [1:0] efa, input logic [1:0] efb,
      input logic espc, input logic esif, input logic ebub,
      input logic efl, input logic eho);
      vectors++;
      if ({fwd_a, fwd_b, stall_pc, stall_ifid, bubble_idex, flush_ifid, halted}
          !== {efa, efb, espc, esif, ebub, efl, eho}) begin
         miscompares++;
         $display("FAIL %s: got fa=%0d fb=%0d spc=%0b sif=%0b bub=%0b fl=%0b hlt=%0b, want fa=%0d fb=%0d spc=%0b sif=%0b bub=%0b fl=%0b hlt=%0b",
                  name, fwd_a, fwd_b, stall_pc, stall_ifid, bubble_idex,
                  flush_ifid, halted, efa, efb, espc, esif, ebub, efl, eho);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   // In-flight producers one and two instructions ahead of ID; a
   // non-producer is stored with destination 0.
   logic       m_ex_v, m_ex_ld, m_mem_v;
   logic [3:0] m_ex_w, m_mem_w;
   logic [1:0] m_fa, m_fb;
   int         m_age;   // edges since HLT accepted, 0 = running

   task automatic model_reset();
      m_ex_v = 0; m_ex_ld = 0; m_ex_w = 0; m_mem_v = 0; m_mem_w = 0;
      m_fa = 0; m_fb = 0; m_age = 0;
   endtask

   function automatic logic [1:0] pick(input logic used, input logic [3:0] src);
      if (!used) return 2'd0;
      if (m_ex_v && m_ex_w != 0 && m_ex_w == src) return 2'd1;
      if (m_mem_v && m_mem_w != 0 && m_mem_w == src) return 2'd2;
      return 2'd0;
   endfunction

   task automatic reset_pulse();
      @(negedge clk);
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      check("rst_pulse", 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, got running want finished");
      $fatal(1);
   end

   initial begin
      logic       v, rsu, rtu, rw, mr, hl, br, lu, adv, est, ebub, efl, eho;
      logic [3:0] rs, rt, wr;
      logic [1:0] nfa, nfb;
      int         hcount;

      // ADD R3 / SUB R4,R3,R5 -> fwd_a=01
      tbl[0]  = mk(1,1,2,1,1,3,1,0,0,0, 0,0,0,0,0,0,0);
      tbl[1]  = mk(1,3,5,1,1,4,1,0,0,0, 0,0,0,0,0,0,0);
      tbl[2]  = mk(0,0,0,0,0,0,0,0,0,0, 1,0,0,0,0,0,0);
      // ADD R3 / OR R8 / XOR R6,R5,R3 -> fwd_b=10
      tbl[3]  = mk(1,1,2,1,1,3,1,0,0,0, 0,0,0,0,0,0,0);
      tbl[4]  = mk(1,1,2,1,1,8,1,0,0,0, 0,0,0,0,0,0,0);
      tbl[5]  = mk(1,5,3,1,1,6,1,0,0,0, 0,0,0,0,0,0,0);
      tbl[6]  = mk(0,0,0,0,0,0,0,0,0,0, 0,2,0,0,0,0,0);
      // LW R2 / ADD R7,R2,R1 -> one stall, then fwd_a=10
      tbl[7]  = mk(1,1,0,1,0,2,1,1,0,0, 0,0,0,0,0,0,0);
      tbl[8]  = mk(1,2,1,1,1,7,1,0,0,0, 0,0,1,1,1,0,0);
      tbl[9]  = mk(1,2,1,1,1,7,1,0,0,0, 0,0,0,0,0,0,0);
      tbl[10] = mk(0,0,0,0,0,0,0,0,0,0, 2,0,0,0,0,0,0);
      // R0 writer / R0 reader, then two R3 writers -> nearest wins
      tbl[11] = mk(1,1,2,1,1,0,1,0,0,0, 0,0,0,0,0,0,0);
      tbl[12] = mk(1,0,0,1,1,5,1,0,0,0, 0,0,0,0,0,0,0);
      tbl[13] = mk(1,1,2,1,1,3,1,0,0,0, 0,0,0,0,0,0,0);
      tbl[14] = mk(1,1,2,1,1,3,1,0,0,0, 0,0,0,0,0,0,0);
      tbl[15] = mk(1,3,3,1,1,9,1,0,0,0, 0,0,0,0,0,0,0);
      tbl[16] = mk(0,0,0,0,0,0,0,0,0,0, 1,1,0,0,0,0,0);
      // LW R4 / ADD R10,R4,R4 with taken branch: flush wins, no forward
      tbl[17] = mk(1,1,0,1,0,4,1,1,0,0, 0,0,0,0,0,0,0);
      tbl[18] = mk(1,4,4,1,1,10,1,0,0,1, 0,0,0,0,1,1,0);
      tbl[19] = mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0);
      tbl[20] = mk(1,10,10,1,1,1,1,0,0,0, 0,0,0,0,0,0,0);
      tbl[21] = mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0);
      // HLT: stall immediately, halted three edges later
      tbl[22] = mk(1,0,0,0,0,0,0,0,1,0, 0,0,1,1,1,0,0);
      tbl[23] = mk(1,0,0,0,0,0,0,0,1,0, 0,0,1,1,1,0,0);
      tbl[24] = mk(1,0,0,0,0,0,0,0,1,0, 0,0,1,1,1,0,0);
      tbl[25] = mk(1,0,0,0,0,0,0,0,1,0, 0,0,1,1,1,0,1);
      tbl[26] = mk(1,0,0,0,0,0,0,0,1,0, 0,0,1,1,1,0,1);

      // reset state: outputs low even with hazard-looking inputs
      drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      #2;
      check("reset", 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;

      for (int i = 0; i < 27; i++) begin
         @(negedge clk);
         drive(tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].rsu, tbl[i].rtu,
               tbl[i].wr, tbl[i].rw, tbl[i].mr, tbl[i].hl, tbl[i].br);
         #2;
         check($sformatf("tbl[%0d]", i), tbl[i].fa, tbl[i].fb, tbl[i].spc,
               tbl[i].sif, tbl[i].bub, tbl[i].fl, tbl[i].ho);
      end

      // reset pulled low in the middle of DRAIN
      reset_pulse();
      @(negedge clk);
      drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      #2;
      check("hlt_accept", 0, 0, 1, 1, 1, 0, 0);
      @(negedge clk);
      #2;
      check("drain", 0, 0, 1, 1, 1, 0, 0);
      #1;
      rst = 1'b0;
      #1;
      check("rst_mid_drain", 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b1;
      drive(1, 1, 2, 1, 1, 3, 1, 0, 0, 0);
      #2;
      check("run_after_rst", 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
         #2;
         check($sformatf("idle_after_rst[%0d]", i), 0, 0, 0, 0, 0, 0, 0);
      end

      // randomized traffic against the reference model
      reset_pulse();
      hcount = 0;
      for (int n = 0; n < 3000; n++) begin
         if (hcount > 3 || $urandom_range(0, 199) == 0) begin
            reset_pulse();
            hcount = 0;
         end
         v   = ($urandom_range(0, 3) != 0);
         rs  = 4'($urandom_range(0, 3));
         rt  = 4'($urandom_range(0, 3));
         rsu = ($urandom_range(0, 3) != 0);
         rtu = ($urandom_range(0, 3) != 0);
         wr  = 4'($urandom_range(0, 3));
         rw  = ($urandom_range(0, 3) != 0);
         mr  = ($urandom_range(0, 4) < 2);
         hl  = ($urandom_range(0, 49) == 0);
         br  = ($urandom_range(0, 11) == 0);
         @(negedge clk);
         drive(v, rs, rt, rsu, rtu, wr, rw, mr, hl, br);
         #2;
         eho = (m_age >= DRAIN);
         lu  = v && m_ex_v && m_ex_ld && (m_ex_w != 0) &&
               ((rsu && rs == m_ex_w) || (rtu && rt == m_ex_w));
         est = 0; ebub = 0; efl = 0;
         if (eho) begin
            est = 1; ebub = 1;
         end else if (br) begin
            efl = 1; ebub = 1;
         end else if (m_age != 0 || lu || (v && hl)) begin
            est = 1; ebub = 1;
         end
         check($sformatf("rand[%0d]", n), m_fa, m_fb, est, est, ebub, efl, eho);

         adv = v && !ebub;
         nfa = adv ? pick(rsu, rs) : 2'd0;
         nfb = adv ? pick(rtu, rt) : 2'd0;
         m_mem_v = m_ex_v;
         m_mem_w = m_ex_w;
         m_ex_v  = adv;
         m_ex_w  = (adv && rw) ? wr : 4'd0;
         m_ex_ld = adv && mr;
         m_fa = nfa;
         m_fb = nfb;
         if (m_age == 0) begin
            if (v && hl && !br && !lu) m_age = 1;
         end else if (m_age < DRAIN) begin
            m_age = br ? 0 : m_age + 1;
         end
         if (eho) hcount++;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
